// File: rtl/count_snapshot_if.sv
// Valid/ready snapshot stream from count_snapshot to its consumer.
// The master drives valid and data; the slave drives ready.
interface count_snapshot_if #(
    parameter int unsigned DATA_W = 10
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/count_snapshot.sv
// Samples the event counter each rising edge and queues tagged snapshots
// {tag, count} on snap, match and wrap events into a small FIFO.
module count_snapshot #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic [WIDTH-1:0]       count_in,
    input  logic                   snap,
    input  logic                   match_en,
    input  logic [WIDTH-1:0]       match_val,
    count_snapshot_if.master       out_bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned DATA_W = WIDTH + 2;

    localparam logic [1:0] TAG_SNAP  = 2'b00;
    localparam logic [1:0] TAG_MATCH = 2'b01;
    localparam logic [1:0] TAG_WRAP  = 2'b10;

    logic [WIDTH-1:0]  count_q;
    logic              prev_valid;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wrap_ev;
    logic              match_ev;
    logic              any_ev;
    logic [1:0]        tag;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              push;
    logic              drop;
    logic              full;
    logic [PTR_W-1:0]  rd_next;
    logic [LVL_W-1:0]  level_next;
    logic [DATA_W-1:0] head_next;

    // Event detection, push/pop decisions and next head of queue
    always_comb begin
        wrap_ev    = prev_valid && (count_q == '1) && (count_in == '0);
        // Only the first cycle at a value matches, so a held count matches once
        match_ev   = match_en && (count_in == match_val) &&
                     (!prev_valid || (count_in != count_q));
        any_ev     = wrap_ev || match_ev || snap;
        tag        = TAG_SNAP;
        if (wrap_ev)       tag = TAG_WRAP;
        else if (match_ev) tag = TAG_MATCH;
        push_data  = {tag, count_in};

        pop        = out_bus.valid && out_bus.ready;
        full       = (level == LVL_W'(DEPTH));
        push       = any_ev && (!full || pop);
        drop       = any_ev && full && !pop;

        rd_next    = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        level_next = level;
        if (push && !pop)      level_next = level + LVL_W'(1);
        else if (pop && !push) level_next = level - LVL_W'(1);

        // A push into a FIFO that is empty after this edge becomes the head directly
        head_next  = (push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
    end

    // Counter sample, pointers, registered outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q       <= '0;
            prev_valid    <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            overflow      <= 1'b0;
            out_bus.valid <= 1'b0;
            out_bus.data  <= '0;
        end else begin
            count_q       <= count_in;
            prev_valid    <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr        <= rd_next;
            level         <= level_next;
            out_bus.valid <= (level_next != '0);
            out_bus.data  <= head_next;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_count_snapshot.sv
// Directed bench for count_snapshot: reset, snap, wrap/match priority,
// match qualification, overflow, full push+pop and mid-run reset.
module tb_count_snapshot;
    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] count_in;
    logic       snap;
    logic       match_en;
    logic [7:0] match_val;
    logic [2:0] level;
    logic       overflow;
    logic       ovf_clr;
    int         errors = 0;
    int         checks = 0;

    count_snapshot_if #(.DATA_W(10)) bus ();

    count_snapshot #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .clr_n(clr_n), .count_in(count_in), .snap(snap),
        .match_en(match_en), .match_val(match_val), .out_bus(bus),
        .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; count_in = 8'd0; snap = 1'b0; match_en = 1'b0;
        match_val = 8'd0; bus.ready = 1'b0; ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            count_in = 8'(i * 85);
            cyc();
        end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.valid); end
        checks++; if (bus.data !== 10'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.data); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
        clr_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            count_in = 8'(c);
            cyc();
            checks++; if (level !== 3'd0 || bus.valid !== 1'b0) begin errors++; $display("FAIL idle_no_push c=%0d: level %0d valid %0b want 0 0", c, level, bus.valid); end
        end
    endtask

    task automatic test_snap();
        bus.ready = 1'b1; count_in = 8'd5; snap = 1'b1;
        cyc();
        snap = 1'b0;
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL snap_valid: got %0b want 1", bus.valid); end
        checks++; if (bus.data !== {2'b00, 8'd5}) begin errors++; $display("FAIL snap_data: got %0h want %0h", bus.data, {2'b00, 8'd5}); end
        count_in = 8'd6;
        cyc();
        checks++; if (bus.valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL snap_drained: valid %0b level %0d want 0 0", bus.valid, level); end
    endtask

    task automatic test_wrap_match();
        bus.ready = 1'b0; match_en = 1'b1; match_val = 8'd0;
        count_in = 8'd254; cyc();
        count_in = 8'd255; cyc();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL pre_wrap_level: got %0d want 0", level); end
        count_in = 8'd0; cyc();
        cyc();
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL wrap_level: got %0d want 1", level); end
        checks++; if (bus.data !== {2'b10, 8'd0}) begin errors++; $display("FAIL wrap_data: got %0h want %0h", bus.data, {2'b10, 8'd0}); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %0b want 0", overflow); end
        bus.ready = 1'b1; count_in = 8'd7; cyc();
        // Snap coinciding with a match is merged under the match tag
        bus.ready = 1'b0; match_val = 8'd30; count_in = 8'd30; snap = 1'b1; cyc();
        snap = 1'b0; count_in = 8'd31; cyc();
        checks++; if (level !== 3'd1 || bus.data !== {2'b01, 8'd30}) begin errors++; $display("FAIL prio_match_snap: level %0d data %0h want 1 %0h", level, bus.data, {2'b01, 8'd30}); end
        bus.ready = 1'b1; match_en = 1'b0; cyc();
    endtask

    task automatic test_match_hold();
        bus.ready = 1'b0; match_en = 1'b1; match_val = 8'd0;
        count_in = 8'd1; cyc();
        count_in = 8'd0;
        for (int i = 0; i < 5; i++) cyc();
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL hold_level: got %0d want 1", level); end
        checks++; if (bus.data !== {2'b01, 8'd0}) begin errors++; $display("FAIL hold_data: got %0h want %0h", bus.data, {2'b01, 8'd0}); end
        bus.ready = 1'b1; cyc();
        checks++; if (level !== 3'd0 || bus.valid !== 1'b0) begin errors++; $display("FAIL hold_drain: level %0d valid %0b want 0 0", level, bus.valid); end
        match_en = 1'b0; count_in = 8'd9; cyc();
    endtask

    task automatic test_overflow();
        bus.ready = 1'b0;
        for (int c = 10; c <= 14; c++) begin
            count_in = 8'(c); snap = 1'b1;
            cyc();
            if (c < 14) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early c=%0d: got %0b want 0", c, overflow); end
            end
        end
        snap = 1'b0; count_in = 8'd15;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d want 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", overflow); end
        cyc();
        checks++; if (bus.valid !== 1'b1 || bus.data !== {2'b00, 8'd10}) begin errors++; $display("FAIL full_hold: valid %0b data %0h want 1 %0h", bus.valid, bus.data, {2'b00, 8'd10}); end
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.valid !== 1'b1 || bus.data !== {2'b00, 8'(10 + i)}) begin errors++; $display("FAIL drain_order i=%0d: valid %0b data %0h want 1 %0h", i, bus.valid, bus.data, {2'b00, 8'(10 + i)}); end
            cyc();
        end
        checks++; if (level !== 3'd0 || bus.valid !== 1'b0) begin errors++; $display("FAIL drain_empty: level %0d valid %0b want 0 0", level, bus.valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        bus.ready = 1'b0;
        for (int c = 16; c <= 19; c++) begin
            count_in = 8'(c); snap = 1'b1; cyc();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL pp_fill: got %0d want 4", level); end
        bus.ready = 1'b1; count_in = 8'd20; snap = 1'b1; cyc();
        snap = 1'b0; count_in = 8'd21;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL pp_level: got %0d want 4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf: got %0b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.valid !== 1'b1 || bus.data !== {2'b00, 8'(17 + i)}) begin errors++; $display("FAIL pp_order i=%0d: valid %0b data %0h want 1 %0h", i, bus.valid, bus.data, {2'b00, 8'(17 + i)}); end
            cyc();
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL pp_empty: got %0d want 0", level); end
    endtask

    task automatic test_reset_mid();
        bus.ready = 1'b0;
        count_in = 8'd40; snap = 1'b1; cyc();
        count_in = 8'd41; cyc();
        snap = 1'b0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL mid_fill: got %0d want 2", level); end
        #2 clr_n = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_reset_async: valid %0b level %0d want 0 0", bus.valid, level); end
        cyc();
        clr_n = 1'b1; count_in = 8'd42; cyc();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_after: got %0d want 0", level); end
    endtask

    initial begin
        test_reset();
        test_snap();
        test_wrap_match();
        test_match_hold();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
